// File: rtl/posit_mult_arbiter.sv
// ============================================================================
// Module   : posit_mult_arbiter (with combinational Optimised_PM posit multiplier)
// Purpose  : Round-robin sharing of one posit multiplier between two requesters,
//            two-stage pipeline (operands, result), result tagged with requester id.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module Optimised_PM #(
  parameter int N  = 8,
  parameter int ES = 4
) (
  input  logic [N-1:0] in1_i,
  input  logic [N-1:0] in2_i,
  output logic [N-1:0] out_o
);

  localparam int c_fw  = N - 1 - ES;
  localparam int c_mw  = c_fw + 1;
  localparam int c_pw  = 2 * c_mw;
  localparam int c_sw  = 2 + ES + (c_pw - 1) + N;
  localparam int c_scw = ES + $clog2(N) + 3;
  localparam logic signed [c_scw-1:0] c_kmax = c_scw'(N - 2);
  localparam logic signed [c_scw-1:0] c_kmin = -c_kmax;
  localparam logic signed [c_scw-1:0] c_sc1  = c_scw'(1);
  localparam logic [N-2:0] c_one = {{(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] c_nar = {1'b1, {(N-1){1'b0}}};

  // Returns {scale, 1.fraction} of a non-zero, non-NaR posit.
  function automatic logic [c_scw+c_mw-1:0] decode(input logic [N-1:0] x);
    logic [N-1:0] a;
    logic [N-2:0] body;
    logic [N-2:0] rem;
    logic r0;
    logic done;
    int m;
    logic signed [c_scw-1:0] k;
    logic signed [c_scw-1:0] sc;
    a    = x[N-1] ? -x : x;
    body = a[N-2:0];
    r0   = body[N-2];
    m    = 0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && (body[i] == r0)) m++;
      else done = 1'b1;
    end
    k   = r0 ? c_scw'(m - 1) : c_scw'(-m);
    rem = body << (m + 1);
    sc  = (k <<< ES) + c_scw'(rem[N-2 -: ES]);
    return {sc, 1'b1, rem[c_fw-1:0]};
  endfunction

  logic signed [c_scw-1:0] w_sc_a, w_sc_b, w_sc, w_k;
  logic [c_mw-1:0]         w_ma, w_mb;
  logic [c_pw-1:0]         w_prod;
  logic [c_pw-2:0]         w_frac;
  logic [ES-1:0]           w_e;
  logic [c_scw-1:0]        w_shamt;
  logic signed [c_sw-1:0]  w_pat, w_shf;
  logic [N-2:0]            w_res;
  logic                    w_guard, w_sticky, w_sign;

  always_comb begin
    {w_sc_a, w_ma} = decode(in1_i);
    {w_sc_b, w_mb} = decode(in2_i);
    w_sign = in1_i[N-1] ^ in2_i[N-1];
    w_prod = c_pw'(w_ma) * c_pw'(w_mb);
    if (w_prod[c_pw-1]) begin
      w_frac = w_prod[c_pw-2:0];
      w_sc   = w_sc_a + w_sc_b + c_sc1;
    end else begin
      w_frac = {w_prod[c_pw-3:0], 1'b0};
      w_sc   = w_sc_a + w_sc_b;
    end
    w_k = w_sc >>> ES;
    w_e = w_sc[ES-1:0];
    // Regime run is produced by sign-filling a 2-bit seed during the right shift.
    w_shamt = w_k[c_scw-1] ? ~w_k : w_k;
    w_pat   = w_k[c_scw-1] ? {2'b01, w_e, w_frac, {N{1'b0}}}
                           : {2'b10, w_e, w_frac, {N{1'b0}}};
    w_shf    = w_pat >>> w_shamt;
    w_res    = w_shf[c_sw-1 -: N-1];
    w_guard  = w_shf[c_sw-N];
    w_sticky = |w_shf[c_sw-N-1:0];
    if (w_guard && (w_sticky || w_res[0])) w_res = w_res + c_one;
    if (w_k > c_kmax)      w_res = '1;
    else if (w_k < c_kmin) w_res = c_one;
    out_o = w_sign ? -{1'b0, w_res} : {1'b0, w_res};
    if ((in1_i == c_nar) || (in2_i == c_nar))     out_o = c_nar;
    else if ((in1_i == '0) || (in2_i == '0))      out_o = '0;
  end

endmodule

module posit_mult_arbiter #(
  parameter int N  = 8,
  parameter int ES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_in1,
  input  logic [N-1:0] req0_in2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_in1,
  input  logic [N-1:0] req1_in2,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_out,
  output logic         res_id,
  output logic         res_nar,
  output logic         busy
);

  localparam logic [N-1:0] c_nar = {1'b1, {(N-1){1'b0}}};

  logic         op_valid_q, op_valid_d;
  logic [N-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic         op_id_q, op_id_d;
  logic         res_valid_q, res_valid_d;
  logic [N-1:0] res_out_q, res_out_d;
  logic         res_id_q, res_id_d;
  logic         res_nar_q, res_nar_d;
  logic         last_grant_q, last_grant_d;

  logic         w_s2_load, w_s1_free, w_grant, w_accept;
  logic [N-1:0] w_mult_out;

  Optimised_PM #(.N(N), .ES(ES)) u_mult (
    .in1_i (op_a_q),
    .in2_i (op_b_q),
    .out_o (w_mult_out)
  );

  always_comb begin
    w_s2_load = op_valid_q && (!res_valid_q || res_ready);
    w_s1_free = !op_valid_q || w_s2_load;
    // Under contention the requester not served last wins.
    w_grant   = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    req0_ready = w_s1_free && !w_grant && req0_valid;
    req1_ready = w_s1_free &&  w_grant && req1_valid;
    w_accept   = req0_ready || req1_ready;

    op_valid_d   = op_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_out_d    = res_out_q;
    res_id_d     = res_id_q;
    res_nar_d    = res_nar_q;

    if (w_accept) begin
      op_valid_d   = 1'b1;
      op_a_d       = w_grant ? req1_in1 : req0_in1;
      op_b_d       = w_grant ? req1_in2 : req0_in2;
      op_id_d      = w_grant;
      last_grant_d = w_grant;
    end else if (w_s2_load) begin
      op_valid_d = 1'b0;
    end

    if (w_s2_load) begin
      res_valid_d = 1'b1;
      res_out_d   = w_mult_out;
      res_id_d    = op_id_q;
      res_nar_d   = (w_mult_out == c_nar);
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_out_q    <= '0;
      res_id_q     <= 1'b0;
      res_nar_q    <= 1'b0;
    end else begin
      op_valid_q   <= op_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_out_q    <= res_out_d;
      res_id_q     <= res_id_d;
      res_nar_q    <= res_nar_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_id    = res_id_q;
  assign res_nar   = res_nar_q;
  assign busy      = op_valid_q || res_valid_q;

endmodule

`default_nettype wire
